apb_rr_scheduler: RTL and testbench
===================================

// Module: apb_rr_scheduler
// PURPOSE
//  Shares one apb_interface master port among NREQ requesters. Round-robin arbitration, one transfer at a time.
//  Per transfer: drives start_transfer/rw_mode/address/data for a fixed window, waits a settle gap, then returns
//  slave_rdata to the granted requester. Sits between the system-side requesters and apb_interface.
// PARAMETERS
//  NREQ        2   number of requesters (2..8)
//  AW          8   address width (matches master_waddr/master_raddr)
//  DW          8   data width (matches master_wdata/slave_rdata)
//  XFER_CYCLES 2   cycles start_transfer is held high per transfer (1..255)
//  GAP_CYCLES  2   idle cycles after start_transfer falls, before rdata sampled (0..255)
// PORTS
//  sys_clk        in   1        system clock, all logic on rising edge
//  sys_reset      in   1        reset: synchronous, active-low
//  req_valid      in   NREQ     per-requester request; held until matching req_ready
//  req_rw         in   NREQ     per-requester mode, 1=write 0=read
//  req_addr       in   NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
//  req_wdata      in   NREQ*DW  flattened write data, requester i at [i*DW +: DW]
//  req_ready      out  NREQ     one-hot accept pulse (combinational, IDLE only)
//  resp_valid     out  NREQ     one-hot completion pulse, 1 cycle, registered
//  resp_rdata     out  DW       read data, valid with resp_valid
//  busy           out  1        1 in any state other than IDLE
//  start_transfer out  1        to apb_interface
//  rw_mode        out  1        to apb_interface, 1=write
//  master_wdata   out  DW       to apb_interface
//  master_waddr   out  AW       to apb_interface
//  master_raddr   out  AW       to apb_interface
//  slave_rdata    in   DW       from apb_interface
// BEHAVIOUR
//  Reset (sys_reset==0 at edge): state=IDLE, counter=0, rr pointer so requester 0 has top priority;
//   all outputs 0 (req_ready 0 since reset dominates). Reset mid-transfer drops it: no resp_valid ever issued.
//  FSM IDLE -> XFER -> GAP -> RESP -> IDLE.
//  IDLE: grant g = first i with req_valid[i], searching from (last_grant+1) mod NREQ upward with wrap.
//   req_ready[g]=1 same cycle; at edge latch rw/addr/wdata of g, last_grant<=g, cnt<=0, go XFER.
//   No req_valid -> stay IDLE, all handshake outputs 0.
//  XFER: start_transfer=1 exactly XFER_CYCLES cycles; rw_mode=latched rw; master_waddr=master_raddr=latched addr;
//   master_wdata=latched wdata if write else 0. Bus outputs registered, stable through XFER and GAP.
//  GAP: start_transfer=0 for GAP_CYCLES cycles (GAP_CYCLES=0 -> XFER goes directly to RESP).
//  RESP: one cycle; resp_rdata<=slave_rdata if read, 0 if write; resp_valid[g]<=1 next edge (1-cycle pulse);
//   then IDLE. resp_rdata holds until next RESP.
//  Latency: req_ready cycle to resp_valid = XFER_CYCLES+GAP_CYCLES+2 edges. Min issue interval same.
//  req_valid changes on non-granted lines during a transfer are ignored; they compete at next IDLE.
//  Dropping req_valid before req_ready is legal (request withdrawn). Requests never queued internally.
//  Counter 8 bits; compared against XFER_CYCLES-1 / GAP_CYCLES-1; never wraps in legal configs.
// STRUCTURE
//  Shared header apb_sched_defs.vh: state encodings (ST_IDLE, ST_XFER, ST_GAP, ST_RESP), CNT_W=8.
//  One sub-module: rr_arbiter (NREQ param; inputs req vector + last_grant index; outputs one-hot grant,
//   index, any_req); purely combinational. FSM, counter, latches in top.
// TESTING (NREQ=2, AW=DW=8, XFER=2, GAP=2, bench model of apb_interface with 256x8 memory)
//  T1 single write: req0 w addr 0x15 data 0x11 -> start_transfer high 2 cycles, waddr=0x15, wdata=0x11; resp_valid=01.
//  T2 read-back: req0 r addr 0x15 -> raddr=0x15, resp_valid=01, resp_rdata=0x11 six edges after req_ready.
//  T3 contention: req0 and req1 valid same cycle after reset -> grant order 0,1,0,1 over 4 transfers.
//  T4 fairness: req1 constantly valid, req0 pulses once -> req0 served no later than next IDLE after req1's current xfer.
//  T5 reset mid-XFER: sys_reset=0 in 2nd XFER cycle -> all outputs 0 next edge, no resp_valid, grant restarts at 0.
//  T6 GAP_CYCLES=0 build: read 0xA5 stored at 0x3C -> resp_rdata=0xA5, latency 4 edges, busy high exactly 3 cycles.

Source files
------------

// File: rtl/apb_rr_scheduler_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_rr_scheduler_pkg : FSM state encoding and counter width      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package apb_rr_scheduler_pkg;

  localparam int c_cnt_w = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_rr_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_rr_scheduler_if : scheduler <-> apb_interface signal bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface apb_rr_scheduler_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          start_transfer;
  logic          rw_mode;
  logic [DW-1:0] master_wdata;
  logic [AW-1:0] master_waddr;
  logic [AW-1:0] master_raddr;
  logic [DW-1:0] slave_rdata;

  modport master (
    output start_transfer, rw_mode, master_wdata, master_waddr, master_raddr,
    input  slave_rdata
  );

  modport slave (
    input  start_transfer, rw_mode, master_wdata, master_waddr, master_raddr,
    output slave_rdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_rr_scheduler_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_rr_scheduler_rr_arbiter : combinational round-robin picker   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module apb_rr_scheduler_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  wire  [NREQ-1:0] req,
  input  wire  [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_req
);

  int w_idx;

  // Search starts one past the previous winner and wraps, so the last
  // winner has the lowest priority this round.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    w_idx     = 0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = int'(last_grant) + off;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (!any_req && req[w_idx[IW-1:0]]) begin
        any_req                = 1'b1;
        grant[w_idx[IW-1:0]]   = 1'b1;
        grant_idx              = w_idx[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_rr_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_rr_scheduler : round-robin sharing of one apb_interface port |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module apb_rr_scheduler
  import apb_rr_scheduler_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int XFER_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  wire                 sys_clk,
  input  wire                 sys_reset,
  input  wire  [NREQ-1:0]     req_valid,
  input  wire  [NREQ-1:0]     req_rw,
  input  wire  [NREQ*AW-1:0]  req_addr,
  input  wire  [NREQ*DW-1:0]  req_wdata,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     resp_valid,
  output logic [DW-1:0]       resp_rdata,
  output logic                busy,
  apb_rr_scheduler_if.master  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [IW-1:0]       r_last;
  logic [NREQ-1:0]     r_gnt;
  logic                r_start;
  logic                r_rw;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [NREQ-1:0]     r_resp_valid;
  logic [DW-1:0]       r_resp_rdata;

  logic [NREQ-1:0]     w_grant;
  logic [IW-1:0]       w_grant_idx;
  logic                w_any;

  apb_rr_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx),
    .any_req    (w_any)
  );

  // Accept is only offered while idle and out of reset.
  assign req_ready  = (r_state == ST_IDLE && sys_reset) ? w_grant : '0;
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

  assign bus.start_transfer = r_start;
  assign bus.rw_mode        = r_rw;
  assign bus.master_waddr   = r_addr;
  assign bus.master_raddr   = r_addr;
  assign bus.master_wdata   = r_wdata;

  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last       <= IW'(NREQ - 1);
      r_gnt        <= '0;
      r_start      <= 1'b0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_grant;
            r_last  <= w_grant_idx;
            r_rw    <= req_rw[w_grant_idx];
            r_addr  <= req_addr[w_grant_idx*AW +: AW];
            r_wdata <= req_rw[w_grant_idx] ? req_wdata[w_grant_idx*DW +: DW] : '0;
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (r_cnt == c_cnt_w'(XFER_CYCLES - 1)) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= (GAP_CYCLES == 0) ? ST_RESP : ST_GAP;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == c_cnt_w'(GAP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        ST_RESP: begin
          r_resp_valid <= r_gnt;
          r_resp_rdata <= r_rw ? '0 : bus.slave_rdata;
          r_rw         <= 1'b0;
          r_addr       <= '0;
          r_wdata      <= '0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_apb_rr_scheduler : directed bench, GAP=2 and GAP=0 instances  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_apb_rr_scheduler;

  logic clk = 1'b0;
  logic sys_reset;
  always #5 clk = ~clk;

  logic [1:0]  a_valid, a_rw, a_ready, a_rv;
  logic [15:0] a_addr, a_wdata;
  logic [7:0]  a_rdata;
  logic        a_busy;
  logic [1:0]  b_valid, b_rw, b_ready, b_rv;
  logic [15:0] b_addr, b_wdata;
  logic [7:0]  b_rdata;
  logic        b_busy;

  apb_rr_scheduler_if #(.AW(8), .DW(8)) if_a ();
  apb_rr_scheduler_if #(.AW(8), .DW(8)) if_b ();

  apb_rr_scheduler #(.NREQ(2), .AW(8), .DW(8), .XFER_CYCLES(2), .GAP_CYCLES(2)) u_dut (
    .sys_clk(clk), .sys_reset(sys_reset), .req_valid(a_valid), .req_rw(a_rw),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_ready(a_ready), .resp_valid(a_rv),
    .resp_rdata(a_rdata), .busy(a_busy), .bus(if_a)
  );

  apb_rr_scheduler #(.NREQ(2), .AW(8), .DW(8), .XFER_CYCLES(2), .GAP_CYCLES(0)) u_dut0 (
    .sys_clk(clk), .sys_reset(sys_reset), .req_valid(b_valid), .req_rw(b_rw),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_ready), .resp_valid(b_rv),
    .resp_rdata(b_rdata), .busy(b_busy), .bus(if_b)
  );

  // Simple apb_interface models: 256x8 memory, asynchronous read.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  always @(posedge clk) begin
    if (if_a.start_transfer && if_a.rw_mode) mem_a[if_a.master_waddr] <= if_a.master_wdata;
    if (!sys_reset) mem_b[8'h3C] <= 8'hA5;
    else if (if_b.start_transfer && if_b.rw_mode) mem_b[if_b.master_waddr] <= if_b.master_wdata;
  end
  assign if_a.slave_rdata = mem_a[if_a.master_raddr];
  assign if_b.slave_rdata = mem_b[if_b.master_raddr];

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] g_rdy, g_rv;
  logic [7:0] g_rdata, g_waddr, g_raddr, g_wdata;
  logic       g_rw;
  int         g_edges, g_st, g_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples req_ready, then follows one transfer until resp_valid (bounded).
  task automatic run(input bit sel, input logic [1:0] raise);
    logic [1:0] rv;
    g_edges = -1; g_st = 0; g_busy = 0; g_rv = '0; g_rdata = '0;
    #1;
    g_rdy = sel ? b_ready : a_ready;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        if (sel) b_valid &= ~g_rdy; else a_valid &= ~g_rdy;
        g_waddr = sel ? if_b.master_waddr : if_a.master_waddr;
        g_raddr = sel ? if_b.master_raddr : if_a.master_raddr;
        g_wdata = sel ? if_b.master_wdata : if_a.master_wdata;
        g_rw    = sel ? if_b.rw_mode      : if_a.rw_mode;
      end
      if (e == 2) begin
        if (sel) b_valid |= raise; else a_valid |= raise;
      end
      if (sel ? if_b.start_transfer : if_a.start_transfer) g_st++;
      if (sel ? b_busy : a_busy) g_busy++;
      rv = sel ? b_rv : a_rv;
      if (rv != 2'b00) begin
        g_rv    = rv;
        g_rdata = sel ? b_rdata : a_rdata;
        g_edges = e;
        break;
      end
    end
  endtask

  task automatic do_reset();
    sys_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sys_reset = 1'b1;
  endtask

  initial begin
    logic [1:0] seen;
    logic [1:0] exp_order [4];
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    a_valid = 2'b01; a_rw = '0; a_addr = '0; a_wdata = '0;
    b_valid = '0;    b_rw = '0; b_addr = '0; b_wdata = '0;
    sys_reset = 1'b0;

    // Reset state: requester 0 asking, reset must dominate
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", a_ready, 2'b00);
    check("rst_resp_valid", a_rv, 2'b00);
    check("rst_busy", a_busy, 1'b0);
    check("rst_start", if_a.start_transfer, 1'b0);
    check("rst_rw_mode", if_a.rw_mode, 1'b0);
    check("rst_waddr", if_a.master_waddr, 8'h00);
    check("rst_raddr", if_a.master_raddr, 8'h00);
    check("rst_wdata", if_a.master_wdata, 8'h00);
    check("rst_rdata", a_rdata, 8'h00);
    a_valid = 2'b00;
    sys_reset = 1'b1;

    // T1 single write
    a_valid = 2'b01; a_rw = 2'b01; a_addr = 16'h0015; a_wdata = 16'h0011;
    run(1'b0, 2'b00);
    check("t1_ready", g_rdy, 2'b01);
    check("t1_waddr", g_waddr, 8'h15);
    check("t1_wdata", g_wdata, 8'h11);
    check("t1_rw_mode", g_rw, 1'b1);
    check("t1_start_cycles", g_st, 2);
    check("t1_busy_cycles", g_busy, 5);
    check("t1_latency", g_edges, 6);
    check("t1_resp_valid", g_rv, 2'b01);
    check("t1_rdata_write", g_rdata, 8'h00);
    @(posedge clk); #1;
    check("t1_resp_pulse", a_rv, 2'b00);

    // T2 read-back
    a_valid = 2'b01; a_rw = 2'b00; a_addr = 16'h0015; a_wdata = 16'h00EE;
    run(1'b0, 2'b00);
    check("t2_ready", g_rdy, 2'b01);
    check("t2_raddr", g_raddr, 8'h15);
    check("t2_wdata_read", g_wdata, 8'h00);
    check("t2_rw_mode", g_rw, 1'b0);
    check("t2_latency", g_edges, 6);
    check("t2_resp_valid", g_rv, 2'b01);
    check("t2_rdata", g_rdata, 8'h11);

    // T3 contention after reset: 0,1,0,1
    do_reset();
    a_rw = 2'b00; a_addr = 16'h2015;
    for (int k = 0; k < 4; k++) begin
      a_valid = 2'b11;
      run(1'b0, 2'b00);
      check("t3_grant", g_rdy, exp_order[k]);
      check("t3_resp", g_rv, exp_order[k]);
    end

    // T4 fairness: req1 keeps asking, req0 pulses mid-transfer
    a_valid = 2'b10;
    run(1'b0, 2'b11);
    check("t4_first_grant", g_rdy, 2'b10);
    check("t4_first_resp", g_rv, 2'b10);
    run(1'b0, 2'b10);
    check("t4_req0_served", g_rdy, 2'b01);
    run(1'b0, 2'b10);
    check("t4_req1_again", g_rdy, 2'b10);

    // T5 reset in the second XFER cycle
    a_valid = 2'b11; a_rw = 2'b01; a_addr = 16'h0040; a_wdata = 16'h0077;
    #1;
    check("t5_ready", a_ready, 2'b01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_in_xfer", if_a.start_transfer, 1'b1);
    sys_reset = 1'b0;
    @(posedge clk); #1;
    check("t5_start", if_a.start_transfer, 1'b0);
    check("t5_busy", a_busy, 1'b0);
    check("t5_waddr", if_a.master_waddr, 8'h00);
    check("t5_wdata", if_a.master_wdata, 8'h00);
    check("t5_rw_mode", if_a.rw_mode, 1'b0);
    check("t5_req_ready", a_ready, 2'b00);
    seen = a_rv;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= a_rv;
    end
    check("t5_no_resp", seen, 2'b00);
    sys_reset = 1'b1;
    #1;
    check("t5_restart_grant", a_ready, 2'b01);
    a_valid = 2'b00;

    // T6 GAP_CYCLES=0 instance
    @(posedge clk); #1;
    b_valid = 2'b01; b_rw = 2'b00; b_addr = 16'h003C;
    run(1'b1, 2'b00);
    check("t6_ready", g_rdy, 2'b01);
    check("t6_raddr", g_raddr, 8'h3C);
    check("t6_latency", g_edges, 4);
    check("t6_busy_cycles", g_busy, 3);
    check("t6_start_cycles", g_st, 2);
    check("t6_resp_valid", g_rv, 2'b01);
    check("t6_rdata", g_rdata, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
